// File: rtl/debug_mem_write_tracker_pkg.sv
// Shared debug package for the memory-write tracker and the UART debug unit.
// Holds the tracker FSM encoding, the store-address alignment constant and the
// default table depth / address width that both debug blocks agree on.
package debug_mem_write_tracker_pkg;

   localparam int unsigned DbgAddrWidth = 32;
   localparam int unsigned DbgDepth     = 16;

   // Number of low address bits cleared when word alignment is enabled.
   localparam int unsigned AlignBits = 2;

   typedef enum logic [1:0] {
      StRec  = 2'd0,
      StRead = 2'd1,
      StDone = 2'd2
   } trk_state_e;

endpackage

// File: rtl/debug_mem_write_tracker_if.sv
// Bus between the pipeline/debug unit and the memory-write tracker.
//   i_clear      sync clear of the table and overflow flag
//   i_stop       pipeline stalled, stores ignored
//   i_mem_write  MEM_write bit of the EX/MEM latch
//   i_mem_addr   ALU_result of the EX/MEM latch
//   i_rd_start   pulse: start readout from entry 0
//   i_rd_next    consumer took o_rd_addr, advance
//   o_rd_valid / o_rd_addr / o_rd_last / o_rd_done   readout stream
//   o_count      number of unique entries held
//   o_overflow   sticky: a new address was dropped because the table was full
// Modport slave is the tracker side, master is the pipeline/debug-unit side.
interface debug_mem_write_tracker_if #(
   parameter int unsigned NB_ADDR = 32,
   parameter int unsigned DEPTH   = 16
);
   localparam int unsigned NB_IDX = $clog2(DEPTH);

   logic               i_clear;
   logic               i_stop;
   logic               i_mem_write;
   logic [NB_ADDR-1:0] i_mem_addr;
   logic               i_rd_start;
   logic               i_rd_next;
   logic               o_rd_valid;
   logic [NB_ADDR-1:0] o_rd_addr;
   logic               o_rd_last;
   logic               o_rd_done;
   logic [NB_IDX:0]    o_count;
   logic               o_overflow;

   modport master (
      output i_clear, i_stop, i_mem_write, i_mem_addr, i_rd_start, i_rd_next,
      input  o_rd_valid, o_rd_addr, o_rd_last, o_rd_done, o_count, o_overflow
   );

   modport slave (
      input  i_clear, i_stop, i_mem_write, i_mem_addr, i_rd_start, i_rd_next,
      output o_rd_valid, o_rd_addr, o_rd_last, o_rd_done, o_count, o_overflow
   );

endinterface

// File: rtl/debug_mem_write_tracker_addr_cam.sv
// Address table with parallel match for the memory-write tracker.
//   i_clk, o_reset_pipeline  clock, async active-high reset
//   i_clear                  sync clear of all entries
//   i_wr_en/i_wr_idx/i_wr_addr  write one entry
//   i_cmp_addr               address to look up
//   i_count                  number of valid entries (0..DEPTH)
//   o_hit                    i_cmp_addr equals one of entries [0..i_count-1]
//   i_rd_idx / o_rd_addr     combinational read port
module debug_mem_write_tracker_addr_cam #(
   parameter int unsigned NB_ADDR = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned NB_IDX  = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               o_reset_pipeline,
   input  logic               i_clear,
   input  logic               i_wr_en,
   input  logic [NB_IDX-1:0]  i_wr_idx,
   input  logic [NB_ADDR-1:0] i_wr_addr,
   input  logic [NB_ADDR-1:0] i_cmp_addr,
   input  logic [NB_IDX:0]    i_count,
   output logic               o_hit,
   input  logic [NB_IDX-1:0]  i_rd_idx,
   output logic [NB_ADDR-1:0] o_rd_addr
);

   logic [NB_ADDR-1:0] entry_q [DEPTH];

   always_ff @(posedge i_clk or posedge o_reset_pipeline) begin
      if (o_reset_pipeline) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else if (i_clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else if (i_wr_en) begin
         entry_q[i_wr_idx] <= i_wr_addr;
      end
   end

   // Only entries below i_count take part; stale slots never match.
   always_comb begin
      o_hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((i < 32'(i_count)) && (entry_q[i] == i_cmp_addr)) begin
            o_hit = 1'b1;
         end
      end
   end

   assign o_rd_addr = entry_q[i_rd_idx];

endmodule

// File: rtl/debug_mem_write_tracker.sv
// Tracks the unique data-memory word addresses stored by the pipeline so the
// UART debug unit can read back only the modified words.
//   i_clk             clock, rising edge
//   o_reset_pipeline  async active-high reset from the debug unit
//   bus (slave)       snoop inputs, readout handshake, count and overflow
// States: StRec records stores, StRead streams entries, StDone pulses o_rd_done.
// Entries survive a readout, so successive debug steps accumulate.
module debug_mem_write_tracker
   import debug_mem_write_tracker_pkg::*;
#(
   parameter int unsigned NB_ADDR    = DbgAddrWidth,
   parameter int unsigned DEPTH      = DbgDepth,
   parameter int unsigned WORD_ALIGN = 1
) (
   input  logic                       i_clk,
   input  logic                       o_reset_pipeline,
   debug_mem_write_tracker_if.slave   bus
);

   localparam int unsigned NB_IDX = $clog2(DEPTH);

   localparam logic [NB_IDX:0]    CountOne  = (NB_IDX+1)'(1);
   localparam logic [NB_IDX:0]    CountFull = (NB_IDX+1)'(DEPTH);
   localparam logic [NB_IDX-1:0]  PtrOne    = NB_IDX'(1);
   localparam logic [NB_ADDR-1:0] AlignMask =
      (WORD_ALIGN != 0) ? ~NB_ADDR'((1 << AlignBits) - 1) : '1;

   trk_state_e         state_q, state_d;
   logic [NB_IDX-1:0]  ptr_q, ptr_d;
   logic [NB_IDX:0]    count_q, count_d;
   logic               overflow_q, overflow_d;

   logic [NB_ADDR-1:0] aligned_addr;
   logic               cam_hit;
   logic               cam_wr;
   logic [NB_ADDR-1:0] cam_rd_addr;
   logic               rd_valid;
   logic               rd_last;

   assign aligned_addr = bus.i_mem_addr & AlignMask;

   debug_mem_write_tracker_addr_cam #(
      .NB_ADDR (NB_ADDR),
      .DEPTH   (DEPTH),
      .NB_IDX  (NB_IDX)
   ) u_addr_cam (
      .i_clk            (i_clk),
      .o_reset_pipeline (o_reset_pipeline),
      .i_clear          (bus.i_clear),
      .i_wr_en          (cam_wr),
      .i_wr_idx         (count_q[NB_IDX-1:0]),
      .i_wr_addr        (aligned_addr),
      .i_cmp_addr       (aligned_addr),
      .i_count          (count_q),
      .o_hit            (cam_hit),
      .i_rd_idx         (ptr_q),
      .o_rd_addr        (cam_rd_addr)
   );

   assign rd_valid = (state_q == StRead);
   assign rd_last  = rd_valid && ({1'b0, ptr_q} == (count_q - CountOne));

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      cam_wr     = 1'b0;

      if (bus.i_clear) begin
         state_d    = StRec;
         ptr_d      = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            StRec: begin
               if (bus.i_mem_write && !bus.i_stop && !cam_hit) begin
                  if (count_q == CountFull) begin
                     overflow_d = 1'b1;
                  end else begin
                     cam_wr  = 1'b1;
                     count_d = count_q + CountOne;
                  end
               end
               // count_d already includes a same-cycle store.
               if (bus.i_rd_start) begin
                  ptr_d   = '0;
                  state_d = (count_d == '0) ? StDone : StRead;
               end
            end
            StRead: begin
               if (bus.i_rd_next) begin
                  if (rd_last) begin
                     state_d = StDone;
                  end else begin
                     ptr_d = ptr_q + PtrOne;
                  end
               end
            end
            StDone: begin
               state_d = StRec;
            end
            default: begin
               state_d = StRec;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge o_reset_pipeline) begin
      if (o_reset_pipeline) begin
         state_q    <= StRec;
         ptr_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.o_rd_valid = rd_valid;
   assign bus.o_rd_addr  = rd_valid ? cam_rd_addr : '0;
   assign bus.o_rd_last  = rd_last;
   assign bus.o_rd_done  = (state_q == StDone);
   assign bus.o_count    = count_q;
   assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_debug_mem_write_tracker.sv
// Self-checking bench for debug_mem_write_tracker (DEPTH=4, WORD_ALIGN=1).
// A reference table models the unique aligned addresses; at readout its
// contents are pushed to an expected queue and popped as the DUT streams.
module tb_debug_mem_write_tracker;

   localparam int unsigned Depth = 4;

   typedef struct {
      logic [31:0] addr;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   debug_mem_write_tracker_if #(.NB_ADDR(32), .DEPTH(Depth)) bus ();

   debug_mem_write_tracker #(
      .NB_ADDR    (32),
      .DEPTH      (Depth),
      .WORD_ALIGN (1)
   ) dut (
      .i_clk            (clk),
      .o_reset_pipeline (rst),
      .bus              (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] model [$];
   logic        model_ovf = 1'b0;
   exp_t        exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_write(input logic [31:0] a);
      logic [31:0] al;
      bit          hit;
      al  = a & 32'hFFFF_FFFC;
      hit = 1'b0;
      foreach (model[i]) begin
         if (model[i] == al) hit = 1'b1;
      end
      if (!hit) begin
         if (model.size() < int'(Depth)) model.push_back(al);
         else model_ovf = 1'b1;
      end
   endfunction

   task automatic idle_inputs();
      bus.i_clear     = 1'b0;
      bus.i_stop      = 1'b0;
      bus.i_mem_write = 1'b0;
      bus.i_mem_addr  = '0;
      bus.i_rd_start  = 1'b0;
      bus.i_rd_next   = 1'b0;
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic drive_cycle(input logic wr, input logic [31:0] addr, input logic stop,
                              input logic start, input logic clr);
      bus.i_mem_write = wr;
      bus.i_mem_addr  = addr;
      bus.i_stop      = stop;
      bus.i_rd_start  = start;
      bus.i_clear     = clr;
      if (clr) begin
         model.delete();
         model_ovf = 1'b0;
      end else if (wr && !stop) begin
         model_write(addr);
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 32'(bus.o_count), 32'(model.size()));
      check({tag, ".ovf"}, 32'(bus.o_overflow), 32'(model_ovf));
   endtask

   task automatic do_write(input logic [31:0] addr);
      drive_cycle(1'b1, addr, 1'b0, 1'b0, 1'b0);
      check_state("wr");
   endtask

   // Readout; optionally with a store in the same cycle as i_rd_start.
   task automatic do_read(input logic wr, input logic [31:0] addr);
      exp_t e;
      drive_cycle(wr, addr, 1'b0, 1'b1, 1'b0);
      foreach (model[i]) begin
         e.addr = model[i];
         e.last = (i == model.size() - 1);
         exp_q.push_back(e);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd.valid", 32'(bus.o_rd_valid), 32'd1);
         check("rd.addr", bus.o_rd_addr, e.addr);
         check("rd.last", 32'(bus.o_rd_last), 32'(e.last));
         // Stall a cycle while a store and a restart request are ignored.
         bus.i_mem_write = 1'b1;
         bus.i_mem_addr  = 32'h100;
         bus.i_rd_start  = 1'b1;
         @(posedge clk);
         #1;
         idle_inputs();
         check("hold.addr", bus.o_rd_addr, e.addr);
         bus.i_rd_next = 1'b1;
         @(posedge clk);
         #1;
         bus.i_rd_next = 1'b0;
      end
      check("rd.done", 32'(bus.o_rd_done), 32'd1);
      check("done.valid", 32'(bus.o_rd_valid), 32'd0);
      @(posedge clk);
      #1;
      check("done.pulse", 32'(bus.o_rd_done), 32'd0);
      check_state("post_rd");
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.count", 32'(bus.o_count), 32'd0);
      check("rst.valid", 32'(bus.o_rd_valid), 32'd0);
      check("rst.addr", bus.o_rd_addr, 32'd0);
      check("rst.last", 32'(bus.o_rd_last), 32'd0);
      check("rst.done", 32'(bus.o_rd_done), 32'd0);
      check("rst.ovf", 32'(bus.o_overflow), 32'd0);
      rst = 1'b0;

      // Alignment: 0x0F -> 0x0C, 0x13 -> 0x10.
      do_write(32'h0F);
      do_write(32'h13);
      do_read(1'b0, 32'h0);

      // Dedup.
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check_state("clr1");
      do_write(32'h20);
      do_write(32'h20);
      do_write(32'h20);
      do_write(32'h21);
      do_read(1'b0, 32'h0);

      // Overflow at DEPTH=4.
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) do_write(32'(i * 4));
      check("ovf.set", 32'(bus.o_overflow), 32'd1);
      do_read(1'b0, 32'h0);
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check_state("clr2");

      // Stalled store ignored, then empty readout.
      drive_cycle(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      check_state("stop");
      do_read(1'b0, 32'h0);

      // Step accumulation, last step with a same-cycle store.
      do_write(32'h8);
      do_read(1'b0, 32'h0);
      do_write(32'h8);
      do_write(32'h30);
      do_read(1'b0, 32'h0);
      do_read(1'b1, 32'h50);

      // Clear dropping a same-cycle store and start.
      bus.i_mem_write = 1'b1;
      bus.i_mem_addr  = 32'h60;
      drive_cycle(1'b1, 32'h60, 1'b0, 1'b1, 1'b1);
      check_state("clr3");
      check("clr3.done", 32'(bus.o_rd_done), 32'd0);

      // Async reset in the middle of a readout with ptr=2.
      do_write(32'h0);
      do_write(32'h4);
      do_write(32'h8);
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      repeat (2) begin
         bus.i_rd_next = 1'b1;
         @(posedge clk);
         #1;
         bus.i_rd_next = 1'b0;
      end
      check("mid.addr", bus.o_rd_addr, 32'h8);
      check("mid.last", 32'(bus.o_rd_last), 32'd1);
      rst = 1'b1;
      #1;
      model.delete();
      model_ovf = 1'b0;
      check("arst.count", 32'(bus.o_count), 32'd0);
      check("arst.valid", 32'(bus.o_rd_valid), 32'd0);
      check("arst.ovf", 32'(bus.o_overflow), 32'd0);
      check("arst.addr", bus.o_rd_addr, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_write(32'h44);
      do_read(1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
